// File: rtl/pwm_esc_array.sv
// pwm_esc_array: multi-channel ESC/servo PWM generator with arming sequence, clamp and slew limiting.
// One shared period counter; compare values only reload at the period boundary so pulses never glitch.
module pwm_esc_array #(
  parameter int CHANNELS    = 4,
  parameter int PERIOD_CYC  = 1_000_000,
  parameter int MIN_CYC     = 55_000,
  parameter int MAX_CYC     = 100_000,
  parameter int RAMP_STEP   = 25,
  parameter int RAMP_DIV    = 1,
  parameter int ARM_PERIODS = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     kill,
  input  logic [CHANNELS-1:0]      ch_en,
  input  logic [32*CHANNELS-1:0]   duty_in,
  output logic [CHANNELS-1:0]      pwm_out,
  output logic                     armed,
  output logic [1:0]               state,
  output logic [CHANNELS-1:0]      at_target,
  output logic                     period_start
);

  // state | meaning
  // IDLE  | outputs low, counter/ramp/duty registers cleared
  // ARM   | MIN_CYC pulses on enabled channels for ARM_PERIODS periods
  // RUN   | clamped, slew-limited duty on every channel
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [31:0] PER_M1 = 32'(PERIOD_CYC - 1);
  localparam logic [31:0] MIN_L  = 32'(MIN_CYC);
  localparam logic [31:0] MAX_L  = 32'(MAX_CYC);
  localparam logic [31:0] STEP_L = 32'(RAMP_STEP);
  localparam logic [31:0] DIV_M1 = 32'(RAMP_DIV - 1);
  localparam logic [31:0] ARM_M1 = 32'(ARM_PERIODS - 1);

  state_t      st, st_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] div_cnt, div_nxt;
  logic [31:0] arm_cnt, arm_nxt;
  logic [31:0] cur_duty [CHANNELS];
  logic [31:0] target   [CHANNELS];
  logic [31:0] cmp      [CHANNELS];
  logic [31:0] req      [CHANNELS];
  logic [31:0] clamp    [CHANNELS];
  logic [31:0] ramp     [CHANNELS];
  logic [31:0] cur_nxt  [CHANNELS];
  logic [31:0] tgt_nxt  [CHANNELS];
  logic [31:0] cmp_nxt  [CHANNELS];
  logic [CHANNELS-1:0] pwm_nxt, at_nxt;
  logic        ps_nxt;
  logic        wrap, tick, active, stay;

  assign state = st;
  assign armed = (st == S_RUN);
  assign wrap  = (cnt == PER_M1);
  assign tick  = (div_cnt == DIV_M1);

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: if (enable && !kill) st_nxt = S_ARM;
      S_ARM: begin
        if (kill || !enable)              st_nxt = S_IDLE;
        else if (wrap && arm_cnt == ARM_M1) st_nxt = S_RUN;
      end
      S_RUN:  if (kill || !enable) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // stay: running in this cycle and still running after the edge
  assign active = (st != S_IDLE);
  assign stay   = active && (st_nxt != S_IDLE);

  always_comb begin
    cnt_nxt = 32'd0;
    div_nxt = 32'd0;
    arm_nxt = 32'd0;
    if (stay) begin
      cnt_nxt = wrap ? 32'd0 : cnt + 32'd1;
      div_nxt = tick ? 32'd0 : div_cnt + 32'd1;
    end
    if (st == S_ARM && st_nxt == S_ARM)
      arm_nxt = wrap ? arm_cnt + 32'd1 : arm_cnt;
    ps_nxt = stay && (cnt == 32'd0);
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      req[i] = duty_in[32*i +: 32];
      if (!ch_en[i] || req[i] < MIN_L) clamp[i] = MIN_L;
      else if (req[i] > MAX_L)         clamp[i] = MAX_L;
      else                             clamp[i] = req[i];

      // difference compare keeps the step from ever wrapping past target
      ramp[i] = cur_duty[i];
      if (target[i] > cur_duty[i]) begin
        if (target[i] - cur_duty[i] > STEP_L) ramp[i] = cur_duty[i] + STEP_L;
        else                                  ramp[i] = target[i];
      end else if (cur_duty[i] > target[i]) begin
        if (cur_duty[i] - target[i] > STEP_L) ramp[i] = cur_duty[i] - STEP_L;
        else                                  ramp[i] = target[i];
      end

      cur_nxt[i] = cur_duty[i];
      tgt_nxt[i] = clamp[i];
      cmp_nxt[i] = cmp[i];
      if (st_nxt == S_IDLE) begin
        cur_nxt[i] = 32'd0;
        tgt_nxt[i] = 32'd0;
        cmp_nxt[i] = 32'd0;
      end else begin
        if (st == S_ARM && st_nxt == S_RUN) cur_nxt[i] = MIN_L;
        else if (st == S_RUN && tick)       cur_nxt[i] = ramp[i];
        if (st_nxt == S_ARM)                cmp_nxt[i] = MIN_L;
        else if (wrap)                      cmp_nxt[i] = cur_nxt[i];
      end

      pwm_nxt[i] = stay && (ch_en[i] || st == S_RUN) && (cnt < cmp[i]);
      at_nxt[i]  = (st == S_RUN) && (st_nxt == S_RUN) && (cur_duty[i] == target[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      cnt          <= 32'd0;
      div_cnt      <= 32'd0;
      arm_cnt      <= 32'd0;
      pwm_out      <= '0;
      at_target    <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_duty[i] <= 32'd0;
        target[i]   <= 32'd0;
        cmp[i]      <= 32'd0;
      end
    end else begin
      st           <= st_nxt;
      cnt          <= cnt_nxt;
      div_cnt      <= div_nxt;
      arm_cnt      <= arm_nxt;
      pwm_out      <= pwm_nxt;
      at_target    <= at_nxt;
      period_start <= ps_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_duty[i] <= cur_nxt[i];
        target[i]   <= tgt_nxt[i];
        cmp[i]      <= cmp_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_esc_array.sv
// tb_pwm_esc_array: directed, table-driven checks of arming, clamp/ramp, period-boundary updates,
// channel disable, kill and reset for a 2-channel, 100-clock-period configuration.
module tb_pwm_esc_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  ch_en = 2'b11;
  logic [63:0] duty_in = '0;
  logic [1:0]  pwm_out;
  logic        armed;
  logic [1:0]  state;
  logic [1:0]  at_target;
  logic        period_start;

  int tests = 0;
  int failed = 0;

  pwm_esc_array #(
    .CHANNELS(2), .PERIOD_CYC(100), .MIN_CYC(10), .MAX_CYC(20),
    .RAMP_STEP(1), .RAMP_DIV(50), .ARM_PERIODS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .kill(kill), .ch_en(ch_en),
    .duty_in(duty_in), .pwm_out(pwm_out), .armed(armed), .state(state),
    .at_target(at_target), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  en;
    int          w0;
    int          w1;
    logic        at0;
    logic        at1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_zero(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if ({pwm_out, armed, state, at_target, period_start} != 7'd0) bad++;
    end
    chk(name, bad, 0);
  endtask

  // Called on a negedge; state goes ARM at the next edge, RUN 200 edges later.
  task automatic arm(input logic [1:0] en, input int exp_h0, input int exp_h1);
    int cnt, h0, h1, first0, early_armed;
    cnt = 0; h0 = 0; h1 = 0; first0 = 0; early_armed = 0;
    ch_en = en; enable = 1'b1; kill = 1'b0;
    while (cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (state == 2'd2) break;
      if (armed) early_armed++;
      if (pwm_out[0]) begin
        h0++;
        if (first0 == 0) first0 = cnt;
      end
      if (pwm_out[1]) h1++;
    end
    chk("arm_cycles_to_run", cnt, 201);
    chk("arm_armed_at_run", armed, 1);
    chk("arm_armed_early", early_armed, 0);
    chk("arm_high_ch0", h0, exp_h0);
    chk("arm_high_ch1", h1, exp_h1);
    chk("arm_first_rise_ch0", first0, 2);
  endtask

  // Entered on the negedge where period_start is high (counter = 1); returns on the next one.
  task automatic run_period(input int k);
    int h0, h1;
    logic a0, a1;
    logic [1:0] st;
    h0 = 0; h1 = 0; a0 = 1'b0; a1 = 1'b0; st = 2'd0;
    chk($sformatf("row%0d_period_start", k), period_start, 1);
    for (int n = 0; n < 100; n++) begin
      if (n == 4) begin
        duty_in = {tbl[k].d1, tbl[k].d0};
        ch_en   = tbl[k].en;
      end
      if (n == 60) begin
        a0 = at_target[0];
        a1 = at_target[1];
        st = state;
      end
      if (pwm_out[0]) h0++;
      if (pwm_out[1]) h1++;
      @(negedge clk);
    end
    chk($sformatf("row%0d_width0", k), h0, tbl[k].w0);
    chk($sformatf("row%0d_width1", k), h1, tbl[k].w1);
    chk($sformatf("row%0d_at_target0", k), a0, tbl[k].at0);
    chk($sformatf("row%0d_at_target1", k), a1, tbl[k].at1);
    chk($sformatf("row%0d_state", k), st, 2);
  endtask

  initial begin
    int bad;
    // inputs applied at counter 5; widths are those of the same period (loaded at the previous wrap)
    tbl[0]  = '{32'd50, 32'd5,  2'b11, 10, 10, 1'b0, 1'b1};
    tbl[1]  = '{32'd50, 32'd5,  2'b11, 12, 10, 1'b0, 1'b1};
    tbl[2]  = '{32'd50, 32'd5,  2'b11, 14, 10, 1'b0, 1'b1};
    tbl[3]  = '{32'd50, 32'd5,  2'b11, 16, 10, 1'b0, 1'b1};
    tbl[4]  = '{32'd50, 32'd5,  2'b11, 18, 10, 1'b0, 1'b1};
    tbl[5]  = '{32'd50, 32'd5,  2'b11, 20, 10, 1'b1, 1'b1};
    tbl[6]  = '{32'd10, 32'd5,  2'b11, 20, 10, 1'b0, 1'b1};
    tbl[7]  = '{32'd10, 32'd5,  2'b11, 18, 10, 1'b0, 1'b1};
    tbl[8]  = '{32'd10, 32'd12, 2'b11, 16, 10, 1'b0, 1'b0};
    tbl[9]  = '{32'd10, 32'd12, 2'b11, 14, 12, 1'b0, 1'b1};
    tbl[10] = '{32'd10, 32'd12, 2'b01, 12, 12, 1'b0, 1'b0};
    tbl[11] = '{32'd10, 32'd12, 2'b01, 10, 10, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {pwm_out, armed, state, at_target, period_start}, 0);
    rst_n = 1'b1;
    idle_zero("idle_enable_low", 500);

    arm(2'b11, 20, 20);
    @(negedge clk);
    for (int k = 0; k < 12; k++) run_period(k);

    // kill at counter 3 of a RUN pulse
    repeat (2) @(negedge clk);
    chk("kill_pre_pulse", pwm_out[0], 1);
    kill = 1'b1;
    @(negedge clk);
    chk("kill_pwm", pwm_out, 0);
    chk("kill_state", state, 0);
    chk("kill_armed", armed, 0);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (state != 2'd0 || pwm_out != 2'd0) bad++;
    end
    chk("kill_beats_enable", bad, 0);

    // re-arm with channel 1 disabled: full ARM sequence, no ch1 pulses
    arm(2'b01, 20, 0);

    // asynchronous reset in the middle of a pulse
    @(negedge clk);
    chk("rearm_period_start", period_start, 1);
    repeat (2) @(negedge clk);
    chk("rst_pre_pulse", pwm_out[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {pwm_out, armed, state, at_target, period_start}, 0);
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    idle_zero("post_reset_idle", 500);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
